// File: rtl/pe_ctr_gen.sv
// PE controller for the NPU core: MAC/unit strobe generation, result
// sequencing through a capture stage, and a buffered valid/ready result FIFO.
//
// slot | meaning
// -----+--------------------------------------------------------------
// 0    | load: idle or first MAC; output: idle, burst starts on conv_out
// k    | load: MAC k is receiving data; output: MAC k result is selected
module pe_ctr_gen #(
    parameter int DATA_WIDTH  = 8,
    parameter int DATA_COPIES = 32,
    parameter int NUM_MAC     = 7,
    parameter int FIFO_DEPTH  = 16,
    localparam int RW = DATA_COPIES * 2 * DATA_WIDTH,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [2:0]            i_npe_mode,
    input  logic                  i_mdata_vld,
    input  logic                  i_wdata_vld,
    input  logic [NUM_MAC-1:0]    i_pe_en,
    input  logic                  i_pe_conv_out,
    input  logic                  i_pe_fc_out,
    input  logic                  i_pe_max_out,
    input  logic [NUM_MAC*RW-1:0] i_pe_mac_result,
    input  logic [RW-1:0]         i_pe_max_result,
    input  logic [RW-1:0]         i_pe_acc_result,
    input  logic [RW-1:0]         i_pe_add_result,
    output logic [NUM_MAC-1:0]    o_pe_mac_ld_en,
    output logic [NUM_MAC-1:0]    o_pe_mac_en,
    output logic [NUM_MAC-1:0]    o_pe_mac_clear,
    output logic                  o_pe_max_en,
    output logic                  o_pe_acc_en,
    output logic                  o_pe_add_en,
    output logic                  o_pe_max_clear,
    output logic                  o_pe_acc_clear,
    output logic [RW-1:0]         o_npe_result,
    output logic                  o_npe_result_vld,
    input  logic                  i_npe_result_rdy,
    output logic [CW-1:0]         o_fifo_cnt,
    output logic                  o_stall,
    output logic                  o_ovf
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = NUM_MAC + 3;
    localparam logic [NUM_MAC-1:0] SLOT0     = {{(NUM_MAC-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]      STALL_CNT = CW'(FIFO_DEPTH - NUM_MAC - 1);

    logic mode_mac, mode_fc, mode_add, mode_max, mode_acc;

    assign mode_mac = (i_npe_mode == 3'd1);
    assign mode_fc  = (i_npe_mode == 3'd2);
    assign mode_add = (i_npe_mode == 3'd3);
    assign mode_max = (i_npe_mode == 3'd4);
    assign mode_acc = (i_npe_mode == 3'd5);

    assign o_pe_max_en = mode_max;
    assign o_pe_acc_en = mode_acc;
    assign o_pe_add_en = mode_add;

    // MAC k sees its enable k cycles late, matching the staggered data skew.
    logic [NUM_MAC-1:1] en_dly;

    for (genvar g = 1; g < NUM_MAC; g++) begin : g_dly
        logic [g-1:0] sr;
        if (g == 1) begin : g_one
            always_ff @(posedge i_clk) begin
                if (i_rst) sr <= '0;
                else       sr <= i_pe_en[g];
            end
        end else begin : g_multi
            always_ff @(posedge i_clk) begin
                if (i_rst) sr <= '0;
                else       sr <= {sr[g-2:0], i_pe_en[g]};
            end
        end
        assign en_dly[g] = sr[g-1];
    end

    assign o_pe_mac_en = {en_dly & {(NUM_MAC-1){mode_mac}},
                          i_pe_en[0] & (mode_mac | mode_fc)};

    logic [NUM_MAC-1:0] ld_ptr_q, ld_ptr_d;
    logic [NUM_MAC-2:0] ld_adv;

    always_comb begin
        ld_adv    = '0;
        ld_adv[0] = ld_ptr_q[0] & mode_mac & i_mdata_vld & i_pe_en[1];
        for (int k = 1; k < NUM_MAC - 1; k++)
            ld_adv[k] = ld_ptr_q[k] & i_mdata_vld & i_pe_en[k+1];
    end

    assign ld_ptr_d = {ld_adv, ~|ld_adv};

    always_comb begin
        o_pe_mac_ld_en = '0;
        if (mode_mac)
            o_pe_mac_ld_en = ld_ptr_q & {NUM_MAC{i_mdata_vld}};
        else if (mode_fc | mode_add | mode_max | mode_acc)
            o_pe_mac_ld_en = {{(NUM_MAC-1){1'b0}}, i_mdata_vld};
    end

    logic [NUM_MAC-1:0] out_ptr_q, out_ptr_d, mask_q, mask_live, seq_oen, oen;
    logic [NUM_MAC-2:0] out_adv;

    // A conv_out request uses the fresh enable mask in the same cycle.
    assign mask_live = i_pe_conv_out ? i_pe_en : mask_q;

    always_comb begin
        seq_oen    = out_ptr_q & mask_live;
        seq_oen[0] = i_pe_conv_out & mask_live[0];
        out_adv    = '0;
        out_adv[0] = mode_mac & out_ptr_q[0] & i_pe_conv_out & mask_live[1];
        for (int k = 1; k < NUM_MAC - 1; k++)
            out_adv[k] = mode_mac & out_ptr_q[k] & mask_live[k+1];
    end

    assign out_ptr_d = {out_adv, ~|out_adv};

    always_comb begin
        oen = '0;
        if (mode_mac)
            oen = seq_oen;
        else
            oen[0] = mode_fc & i_pe_en[0] & i_pe_fc_out;
    end

    logic [NUM_MAC-1:0] oen_q;
    logic               max_oen_q, acc_oen_q, add_oen_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ld_ptr_q  <= SLOT0;
            out_ptr_q <= SLOT0;
            mask_q    <= '0;
            oen_q     <= '0;
            max_oen_q <= 1'b0;
            acc_oen_q <= 1'b0;
            add_oen_q <= 1'b0;
        end else begin
            ld_ptr_q  <= ld_ptr_d;
            out_ptr_q <= out_ptr_d;
            if (i_pe_conv_out) mask_q <= i_pe_en;
            oen_q     <= oen;
            max_oen_q <= mode_max & i_pe_max_out;
            acc_oen_q <= mode_acc & i_pe_max_out;
            add_oen_q <= mode_add & (i_mdata_vld | i_wdata_vld);
        end
    end

    assign o_pe_mac_clear = oen_q;
    assign o_pe_max_clear = max_oen_q;
    assign o_pe_acc_clear = acc_oen_q;

    logic [SW-1:0] src_vec;
    logic          wr_en, collide;
    logic [RW-1:0] wr_data;

    assign src_vec = {add_oen_q, acc_oen_q, max_oen_q, oen_q};
    assign wr_en   = |src_vec;
    assign collide = |(src_vec & (src_vec - SW'(1)));

    // Later assignments win, so the lowest-index MAC has top priority.
    always_comb begin
        wr_data = '0;
        if (add_oen_q) wr_data = i_pe_add_result;
        if (acc_oen_q) wr_data = i_pe_acc_result;
        if (max_oen_q) wr_data = i_pe_max_result;
        for (int k = NUM_MAC - 1; k >= 0; k--)
            if (oen_q[k]) wr_data = i_pe_mac_result[k*RW +: RW];
    end

    logic [RW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          pop, push;

    assign pop  = (cnt != '0) & i_npe_result_rdy;
    assign push = wr_en & ((cnt < FULL_CNT) | pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            o_ovf  <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            if (collide | (wr_en & ~push)) o_ovf <= 1'b1;
        end
    end

    assign o_npe_result     = mem[rd_ptr];
    assign o_npe_result_vld = (cnt != '0);
    assign o_fifo_cnt       = cnt;
    assign o_stall          = (cnt >= STALL_CNT);

endmodule

// File: tb/tb_pe_ctr_gen.sv
// Directed bench for pe_ctr_gen with default parameters (7 MACs, 16-entry FIFO).
module tb_pe_ctr_gen;

    localparam int RW = 512;
    localparam int NM = 7;

    logic              clk, rst;
    logic [2:0]        mode;
    logic              mdata, wdata, conv, fc_out, max_out, rdy;
    logic [NM-1:0]     pe_en;
    logic [NM*RW-1:0]  mac_res;
    logic [RW-1:0]     max_res, acc_res, add_res;
    logic [NM-1:0]     ld_en, mac_en, mac_clr;
    logic              max_en, acc_en, add_en, max_clr, acc_clr;
    logic [RW-1:0]     result;
    logic              vld, stall, ovf;
    logic [4:0]        cnt;

    int total = 0;
    int bad   = 0;

    pe_ctr_gen dut (
        .i_clk(clk), .i_rst(rst), .i_npe_mode(mode),
        .i_mdata_vld(mdata), .i_wdata_vld(wdata), .i_pe_en(pe_en),
        .i_pe_conv_out(conv), .i_pe_fc_out(fc_out), .i_pe_max_out(max_out),
        .i_pe_mac_result(mac_res), .i_pe_max_result(max_res),
        .i_pe_acc_result(acc_res), .i_pe_add_result(add_res),
        .o_pe_mac_ld_en(ld_en), .o_pe_mac_en(mac_en), .o_pe_mac_clear(mac_clr),
        .o_pe_max_en(max_en), .o_pe_acc_en(acc_en), .o_pe_add_en(add_en),
        .o_pe_max_clear(max_clr), .o_pe_acc_clear(acc_clr),
        .o_npe_result(result), .o_npe_result_vld(vld),
        .i_npe_result_rdy(rdy), .o_fifo_cnt(cnt), .o_stall(stall), .o_ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [RW-1:0] pat(input int b, input int k);
        logic [31:0] w;
        w = 32'hC0DE_0000 + 32'(b * 16 + k);
        return {(RW/32){w}};
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mac(input int b);
        for (int k = 0; k < NM; k++) mac_res[k*RW +: RW] = pat(b, k);
    endtask

    task automatic idle_inputs();
        mode = 3'd0; mdata = 0; wdata = 0; conv = 0; fc_out = 0; max_out = 0;
        rdy = 0; pe_en = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        nxt(); nxt();
        rst = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        repeat (3) nxt();
        rst = 0;
        @(negedge clk);
        total++; if (ld_en !== 7'h00) begin bad++; $display("FAIL reset_ld got=%h exp=00", ld_en); end
        total++; if (mac_en !== 7'h00) begin bad++; $display("FAIL reset_mac_en got=%h exp=00", mac_en); end
        total++; if (mac_clr !== 7'h00) begin bad++; $display("FAIL reset_clr got=%h exp=00", mac_clr); end
        total++; if ({max_en, acc_en, add_en, max_clr, acc_clr} !== 5'b0) begin bad++; $display("FAIL reset_units got=%b exp=00000", {max_en, acc_en, add_en, max_clr, acc_clr}); end
        total++; if (vld !== 1'b0 || result !== '0) begin bad++; $display("FAIL reset_fifo vld=%b data=%h exp vld=0 data=0", vld, result[31:0]); end
        total++; if (cnt !== 5'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        total++; if (stall !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL reset_flags stall=%b ovf=%b exp 0 0", stall, ovf); end
        nxt();
    endtask

    task automatic test_mac_burst();
        logic [NM-1:0] ec;
        logic          ev;
        mode = 3'd1; pe_en = 7'h7F; rdy = 1; set_mac(0);
        for (int c = 0; c < 10; c++) begin
            conv = (c == 0);
            @(negedge clk);
            ec = '0;
            if (c >= 1 && c <= 7) ec[c-1] = 1'b1;
            ev = (c >= 2 && c <= 8);
            total++; if (mac_clr !== ec) begin bad++; $display("FAIL burst_clr c=%0d got=%h exp=%h", c, mac_clr, ec); end
            total++; if (vld !== ev) begin bad++; $display("FAIL burst_vld c=%0d got=%b exp=%b", c, vld, ev); end
            total++; if (cnt !== (ev ? 5'd1 : 5'd0)) begin bad++; $display("FAIL burst_cnt c=%0d got=%0d exp=%0d", c, cnt, ev); end
            if (ev) begin
                total++; if (result !== pat(0, c - 2)) begin bad++; $display("FAIL burst_data c=%0d got=%h exp=%h", c, result[31:0], pat(0, c - 2) & 32'hFFFF_FFFF); end
            end
            nxt();
        end
        conv = 0;
    endtask

    task automatic test_load_seq();
        logic [NM-1:0] exp_ld  [5];
        logic [NM-1:0] exp_men [5];
        exp_ld  = '{7'h01, 7'h02, 7'h04, 7'h01, 7'h02};
        exp_men = '{7'h01, 7'h03, 7'h07, 7'h07, 7'h07};
        mode = 3'd1; pe_en = '0; mdata = 0;
        repeat (8) nxt();
        pe_en = 7'h07;
        for (int c = 0; c < 5; c++) begin
            mdata = 1;
            @(negedge clk);
            total++; if (ld_en !== exp_ld[c]) begin bad++; $display("FAIL load_ld c=%0d got=%h exp=%h", c, ld_en, exp_ld[c]); end
            total++; if (mac_en !== exp_men[c]) begin bad++; $display("FAIL load_mac_en c=%0d got=%h exp=%h", c, mac_en, exp_men[c]); end
            nxt();
        end
        mdata = 0;
        @(negedge clk);
        total++; if (ld_en !== 7'h00) begin bad++; $display("FAIL load_idle got=%h exp=00", ld_en); end
        nxt();
    endtask

    task automatic test_unit_modes();
        rdy = 1; pe_en = 7'h01;
        mac_res[0 +: RW] = pat(5, 0);
        add_res = pat(6, 0); acc_res = pat(7, 0);
        mode = 3'd2;
        for (int c = 0; c < 4; c++) begin
            fc_out = (c == 0);
            @(negedge clk);
            if (c == 0) begin
                total++; if (mac_en !== 7'h01) begin bad++; $display("FAIL fc_mac_en got=%h exp=01", mac_en); end
            end
            total++; if (mac_clr !== ((c == 1) ? 7'h01 : 7'h00)) begin bad++; $display("FAIL fc_clr c=%0d got=%h", c, mac_clr); end
            total++; if (vld !== (c == 2)) begin bad++; $display("FAIL fc_vld c=%0d got=%b exp=%b", c, vld, c == 2); end
            if (c == 2) begin
                total++; if (result !== pat(5, 0)) begin bad++; $display("FAIL fc_data got=%h exp=%h", result[31:0], pat(5, 0) & 32'hFFFF_FFFF); end
            end
            nxt();
        end
        fc_out = 0;
        mode = 3'd3;
        for (int c = 0; c < 5; c++) begin
            mdata = (c == 0);
            wdata = (c == 1);
            @(negedge clk);
            if (c == 0) begin
                total++; if (add_en !== 1'b1 || ld_en !== 7'h01 || mac_en !== 7'h00) begin bad++; $display("FAIL add_decode add_en=%b ld=%h mac_en=%h exp 1 01 00", add_en, ld_en, mac_en); end
            end
            total++; if (vld !== (c == 2 || c == 3)) begin bad++; $display("FAIL add_vld c=%0d got=%b", c, vld); end
            if (c == 2 || c == 3) begin
                total++; if (result !== pat(6, 0)) begin bad++; $display("FAIL add_data c=%0d got=%h exp=%h", c, result[31:0], pat(6, 0) & 32'hFFFF_FFFF); end
            end
            nxt();
        end
        mdata = 0; wdata = 0;
        mode = 3'd5;
        for (int c = 0; c < 4; c++) begin
            max_out = (c == 0);
            @(negedge clk);
            if (c == 0) begin
                total++; if (acc_en !== 1'b1 || max_en !== 1'b0) begin bad++; $display("FAIL acc_decode acc_en=%b max_en=%b exp 1 0", acc_en, max_en); end
            end
            total++; if (acc_clr !== (c == 1) || max_clr !== 1'b0) begin bad++; $display("FAIL acc_clr c=%0d acc=%b max=%b", c, acc_clr, max_clr); end
            total++; if (vld !== (c == 2)) begin bad++; $display("FAIL acc_vld c=%0d got=%b", c, vld); end
            if (c == 2) begin
                total++; if (result !== pat(7, 0)) begin bad++; $display("FAIL acc_data got=%h exp=%h", result[31:0], pat(7, 0) & 32'hFFFF_FFFF); end
            end
            nxt();
        end
        max_out = 0;
    endtask

    task automatic test_backpressure();
        int wb, ec, b;
        do_reset();
        rdy = 0; mode = 3'd1; pe_en = 7'h7F;
        for (int a = 0; a < 26; a++) begin
            b = a / 8;
            conv = (a % 8 == 0 && b < 3);
            if (conv) set_mac(b);
            @(negedge clk);
            wb = 0;
            for (int w = 0; w < a; w++) if (w < 24 && (w % 8) != 0) wb++;
            ec = (wb > 16) ? 16 : wb;
            total++; if (cnt !== 5'(ec)) begin bad++; $display("FAIL bp_cnt a=%0d got=%0d exp=%0d", a, cnt, ec); end
            total++; if (stall !== (ec >= 8)) begin bad++; $display("FAIL bp_stall a=%0d got=%b exp=%b", a, stall, ec >= 8); end
            total++; if (ovf !== (wb > 16)) begin bad++; $display("FAIL bp_ovf a=%0d got=%b exp=%b", a, ovf, wb > 16); end
            if (ec > 0) begin
                total++; if (result !== pat(0, 0)) begin bad++; $display("FAIL bp_head a=%0d got=%h exp=%h", a, result[31:0], pat(0, 0) & 32'hFFFF_FFFF); end
            end
            nxt();
        end
        conv = 0;
        rdy = 1;
        for (int d = 0; d <= 16; d++) begin
            @(negedge clk);
            total++; if (cnt !== 5'(16 - d)) begin bad++; $display("FAIL drain_cnt d=%0d got=%0d exp=%0d", d, cnt, 16 - d); end
            total++; if (vld !== (d < 16)) begin bad++; $display("FAIL drain_vld d=%0d got=%b", d, vld); end
            if (d < 16) begin
                total++; if (result !== pat(d / 7, d % 7)) begin bad++; $display("FAIL drain_data d=%0d got=%h exp=%h", d, result[31:0], pat(d / 7, d % 7) & 32'hFFFF_FFFF); end
            end
            nxt();
        end
        @(negedge clk);
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", ovf); end
        nxt();
        rdy = 0;
    endtask

    task automatic test_full_pop();
        do_reset();
        rdy = 0; mode = 3'd1; pe_en = 7'h7F;
        for (int a = 0; a < 16; a++) begin
            conv = (a % 8 == 0);
            if (conv) set_mac(a / 8);
            nxt();
        end
        conv = 0;
        mode = 3'd2; pe_en = 7'h01;
        mac_res[0 +: RW] = pat(9, 0);
        for (int q = 0; q < 5; q++) begin
            fc_out = (q < 3);
            rdy = (q == 3);
            @(negedge clk);
            if (q < 3) begin
                total++; if (cnt !== 5'((q == 2) ? 15 : 14)) begin bad++; $display("FAIL fill_cnt q=%0d got=%0d", q, cnt); end
            end else begin
                total++; if (cnt !== 5'd16) begin bad++; $display("FAIL fullpop_cnt q=%0d got=%0d exp=16", q, cnt); end
                total++; if (ovf !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL fullpop_flags q=%0d ovf=%b stall=%b exp 0 1", q, ovf, stall); end
                total++; if (result !== pat(0, q - 3)) begin bad++; $display("FAIL fullpop_head q=%0d got=%h exp=%h", q, result[31:0], pat(0, q - 3) & 32'hFFFF_FFFF); end
            end
            nxt();
        end
        fc_out = 0; rdy = 0;
    endtask

    task automatic test_mode_switch();
        logic [NM-1:0] ec;
        logic          ev;
        do_reset();
        rdy = 1; mode = 3'd1; pe_en = 7'h7F; set_mac(3);
        max_res = pat(8, 0);
        for (int c = 0; c < 14; c++) begin
            conv = (c == 0);
            if (c == 3) mode = 3'd4;
            max_out = (c == 10);
            @(negedge clk);
            ec = '0;
            if (c >= 1 && c <= 3) ec[c-1] = 1'b1;
            ev = (c >= 2 && c <= 4) || (c == 12);
            total++; if (mac_clr !== ec) begin bad++; $display("FAIL sw_clr c=%0d got=%h exp=%h", c, mac_clr, ec); end
            total++; if (vld !== ev) begin bad++; $display("FAIL sw_vld c=%0d got=%b exp=%b", c, vld, ev); end
            total++; if (max_clr !== (c == 11)) begin bad++; $display("FAIL sw_max_clr c=%0d got=%b", c, max_clr); end
            total++; if (max_en !== (c >= 3)) begin bad++; $display("FAIL sw_max_en c=%0d got=%b", c, max_en); end
            if (c >= 2 && c <= 4) begin
                total++; if (result !== pat(3, c - 2)) begin bad++; $display("FAIL sw_data c=%0d got=%h exp=%h", c, result[31:0], pat(3, c - 2) & 32'hFFFF_FFFF); end
            end
            if (c == 12) begin
                total++; if (result !== pat(8, 0)) begin bad++; $display("FAIL sw_max_data got=%h exp=%h", result[31:0], pat(8, 0) & 32'hFFFF_FFFF); end
            end
            nxt();
        end
        conv = 0; max_out = 0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rdy = 0; mode = 3'd1; pe_en = 7'h7F; set_mac(4);
        for (int c = 0; c < 7; c++) begin
            conv = (c == 0);
            rst  = (c == 3);
            @(negedge clk);
            if (c == 3) begin
                total++; if (cnt !== 5'd2) begin bad++; $display("FAIL mid_cnt_pre got=%0d exp=2", cnt); end
            end
            if (c >= 4) begin
                total++; if (mac_clr !== 7'h00 || cnt !== 5'd0 || vld !== 1'b0 || result !== '0) begin bad++; $display("FAIL mid_abort c=%0d clr=%h cnt=%0d vld=%b exp 00 0 0", c, mac_clr, cnt, vld); end
            end
            nxt();
        end
        rst = 0; conv = 0;
    endtask

    initial begin
        mac_res = '0; max_res = '0; acc_res = '0; add_res = '0;
        test_reset();
        test_mac_burst();
        test_load_seq();
        test_unit_modes();
        test_backpressure();
        test_full_pop();
        test_mode_switch();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_ctr_gen.md
Name: pe_ctr_gen

Overview:
- Parametrised next-generation PE controller for the NPU core.
- Drives load, compute-enable and clear strobes for NUM_MAC MAC units plus the max, acc and add units, and sequences their results onto a single result bus.
- Unlike the fixed 7-MAC controller, the result path is buffered in an output FIFO with a valid/ready handshake. It adds upstream stall and a sticky overflow flag.
- Sits between the NPE instruction decoder/data feeders and the result write-back stage.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- DATA_COPIES, 32, elements per vector; RW = DATA_COPIES*2*DATA_WIDTH is the result width.
- NUM_MAC, 7, number of MAC units; legal range 2..16.
- FIFO_DEPTH, 16, output FIFO entries; power of 2, ≥ 2*NUM_MAC.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_npe_mode  in  3  1=mac, 2=fc, 3=add, 4=max, 5=acc; other values = idle
- i_mdata_vld  in  1  feature data valid
- i_wdata_vld  in  1  weight data valid
- i_pe_en  in  NUM_MAC  per-MAC enable mask
- i_pe_conv_out  in  1  conv burst output request
- i_pe_fc_out  in  1  fc output request
- i_pe_max_out  in  1  max/acc output request
- i_pe_mac_result  in  NUM_MAC*RW  MAC k result at bits [k*RW +: RW]
- i_pe_max_result, i_pe_acc_result, i_pe_add_result  in  RW each  unit results
- o_pe_mac_ld_en  out  NUM_MAC  MAC load strobes
- o_pe_mac_en  out  NUM_MAC  MAC compute enables
- o_pe_mac_clear  out  NUM_MAC  MAC clear strobes
- o_pe_max_en, o_pe_acc_en, o_pe_add_en  out  1 each  unit enables
- o_pe_max_clear, o_pe_acc_clear  out  1 each  unit clear strobes
- o_npe_result  out  RW  FIFO head data
- o_npe_result_vld  out  1  FIFO non-empty
- i_npe_result_rdy  in  1  downstream accepts head
- o_fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- o_stall  out  1  upstream must not start a new output burst
- o_ovf  out  1  sticky overflow flag

Behaviour:
- Reset: all registers clear.
  - Every strobe and enable output is 0 and the delay line is 0.
  - Both sequencers return to slot 0; the FIFO is empty (cnt 0, vld 0, o_npe_result 0).
  - o_ovf = 0 and o_stall = 0.
  - Reset asserted mid-burst aborts the burst immediately and drops FIFO contents.
- Mode decode is combinational from i_npe_mode.
  - o_pe_max_en, o_pe_acc_en and o_pe_add_en equal their respective mode.
- Compute enable:
  - o_pe_mac_en[0] = i_pe_en[0] & (mac|fc).
  - For k ≥ 1, o_pe_mac_en[k] = i_pe_en[k] delayed k cycles, ANDed with mac.
- Load sequencer (one-hot pointer over NUM_MAC slots).
  - mac mode: o_pe_mac_ld_en = ptr & {i_mdata_vld}.
  - From slot 0, advance to slot 1 iff mac & i_mdata_vld & i_pe_en[1].
  - From slot k (0<k<NUM_MAC-1), advance to k+1 iff i_mdata_vld & i_pe_en[k+1]; otherwise go to slot 0.
  - The last slot always returns to slot 0.
  - fc/max/add/acc modes: o_pe_mac_ld_en = {0, i_mdata_vld}.
  - idle mode: all load strobes are 0.
- Output sequencer (one-hot), mac mode:
  - On i_pe_conv_out, capture the enable mask m = i_pe_en; the mask is live in the same cycle.
  - oen[0] = i_pe_conv_out & m[0].
  - From slot k, advance to k+1 iff m[k+1]; otherwise return to slot 0. oen = slot & m.
  - fc mode: oen[0] = i_pe_en[0] & i_pe_fc_out.
  - Leaving mac mode forces the sequencer to slot 0 on the next edge.
- Capture stage (registered oen and unit-oen, 1 cycle):
  - In cycle T+1 after oen asserts in cycle T, the selected result is written to the FIFO.
  - In the same cycle the matching clear strobe pulses for 1 cycle.
  - Unit-oen sources: max = max & i_pe_max_out, acc = acc & i_pe_max_out, add = add & (i_mdata_vld | i_wdata_vld).
  - Write priority if more than one is set: mac (lowest k) > max > acc > add. Lower-priority writes are discarded and o_ovf is set.
- FIFO (registered output, no fall-through). A write in T+1 gives o_npe_result_vld in T+2.
  - Pop when vld & rdy.
  - Push accepted if cnt < FIFO_DEPTH, or when full with a simultaneous pop; otherwise data is dropped and o_ovf is set.
  - o_ovf stays set until i_rst.
  - o_npe_result holds its value while vld & !rdy.
  - Pointers wrap modulo FIFO_DEPTH.
- o_stall = (cnt ≥ FIFO_DEPTH-NUM_MAC-1), combinational from cnt.
- End-to-end latency from i_pe_conv_out to first o_npe_result_vld: 2 cycles with an empty FIFO.

Test Plan:
- Reset release: i_rst=1 for 3 cycles, then 0 → all outputs 0, o_fifo_cnt=0, o_ovf=0.
- mac mode, i_pe_en=7'h7F, NUM_MAC=7, rdy=1: pulse i_pe_conv_out at T → o_pe_mac_clear[k] pulses at T+1+k. FIFO delivers MAC0..MAC6 results in order on T+2..T+8, vld continuous.
- mac mode, i_pe_en=7'h07, i_mdata_vld held high 5 cycles → ld_en sequence 0x01, 0x02, 0x04, 0x01, 0x02. o_pe_mac_en[2] rises 2 cycles after i_pe_en[2].
- Backpressure: rdy=0, three conv bursts of 7 with FIFO_DEPTH=16 → o_stall asserts at cnt=8, o_fifo_cnt saturates at 16, o_ovf=1, head data unchanged. Then rdy=1 → 16 ordered results drain.
- Full with simultaneous pop: cnt=16, rdy=1, one push in the same cycle → cnt stays 16, o_ovf unchanged.
- Mode switch mid-burst: change i_npe_mode from 1 to 4 at T+3 of a 7-MAC burst → no MAC clears after T+4. A max burst with i_pe_max_out then yields i_pe_max_result with o_pe_max_clear=1.
